// File: rtl/program_loader.sv
// Instruction-memory loader: frames a byte stream (MAGIC, 16-bit word count, LE words, sum)
// into sequential 32-bit writes, and releases the cpu only after a checksum-valid image.
module program_loader #(
  parameter int          ADDR_WIDTH     = 10,
  parameter logic [7:0]  MAGIC          = 8'hA5,
  parameter int          TIMEOUT_CYCLES = 1000000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  output logic                  mem_write_enable,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [31:0]           mem_write_data,
  output logic                  cpu_enable,
  output logic                  busy,
  output logic                  load_done,
  output logic                  load_error
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, LEN0, LEN1, DATA, CSUM, DONE, ERROR} state_t;

  state_t      state, state_nxt;
  logic        acc, timeout;
  logic [7:0]  count_lo, csum;
  logic [15:0] count, len_n;
  logic [16:0] word_idx;
  logic [1:0]  byte_idx;
  logic [23:0] word_buf;
  logic [TW-1:0] idle_cnt;

  assign acc        = in_valid && in_ready;
  assign len_n      = {in_data, count_lo};
  assign busy       = (state == LEN0) || (state == LEN1) || (state == DATA) || (state == CSUM);
  assign load_done  = (state == DONE);
  assign cpu_enable = (state == DONE);
  assign load_error = (state == ERROR);
  // idle_cnt reaching TIMEOUT_CYCLES-1 with no byte this cycle means the limit is hit at this edge
  assign timeout    = busy && !acc && (idle_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE, ERROR: if (acc && in_data == MAGIC) state_nxt = LEN0;
      LEN0: if (acc) state_nxt = LEN1;
      LEN1: if (acc) begin
        if ({1'b0, len_n} > (17'd1 << ADDR_WIDTH)) state_nxt = ERROR;
        else if (len_n == 16'd0)                   state_nxt = CSUM;
        else                                       state_nxt = DATA;
      end
      DATA: if (acc && byte_idx == 2'd3 && (word_idx + 17'd1) == {1'b0, count}) state_nxt = CSUM;
      CSUM: if (acc) state_nxt = (in_data == csum) ? DONE : ERROR;
      default: state_nxt = IDLE;
    endcase
    if (timeout) state_nxt = ERROR;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      in_ready         <= 1'b0;
      mem_write_enable <= 1'b0;
      mem_address      <= '0;
      mem_write_data   <= '0;
      count_lo         <= '0;
      count            <= '0;
      csum             <= '0;
      word_idx         <= '0;
      byte_idx         <= '0;
      word_buf         <= '0;
      idle_cnt         <= '0;
    end else begin
      in_ready         <= 1'b1;
      mem_write_enable <= 1'b0;
      if (acc || !busy) idle_cnt <= '0;
      else              idle_cnt <= idle_cnt + TW'(1);
      if (acc) begin
        case (state)
          IDLE, DONE, ERROR: if (in_data == MAGIC) csum <= '0;
          LEN0: count_lo <= in_data;
          LEN1: begin
            count    <= len_n;
            word_idx <= '0;
            byte_idx <= '0;
          end
          DATA: begin
            csum     <= csum + in_data;
            byte_idx <= byte_idx + 2'd1;
            case (byte_idx)
              2'd0: word_buf[7:0]   <= in_data;
              2'd1: word_buf[15:8]  <= in_data;
              2'd2: word_buf[23:16] <= in_data;
              default: begin
                // top byte goes straight into the write register, so the strobe lands next cycle
                mem_write_enable <= 1'b1;
                mem_address      <= word_idx[ADDR_WIDTH-1:0];
                mem_write_data   <= {in_data, word_buf};
                word_idx         <= word_idx + 17'd1;
              end
            endcase
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: table of framed byte streams with hand-computed results,
// plus sequences for full-capacity load, timeout, async reset and gapped timing.
module tb_program_loader;

  logic        clock = 1'b0, reset = 1'b0, in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready, mem_write_enable, cpu_enable, busy, load_done, load_error;
  logic [9:0]  mem_address;
  logic [31:0] mem_write_data;

  always #5 clock = ~clock;

  program_loader #(.ADDR_WIDTH(10), .MAGIC(8'hA5), .TIMEOUT_CYCLES(16)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .mem_write_enable(mem_write_enable), .mem_address(mem_address), .mem_write_data(mem_write_data),
    .cpu_enable(cpu_enable), .busy(busy), .load_done(load_done), .load_error(load_error));

  int nvec = 0, nerr = 0;
  logic [31:0] sq_d[$];
  int          sq_a[$];

  always @(negedge clock)
    if (mem_write_enable === 1'b1) begin
      sq_a.push_back(int'(mem_address));
      sq_d.push_back(mem_write_data);
    end

  typedef struct {
    int           nb;
    logic [127:0] bytes;
    int           mk;
    logic         done;
    logic         err;
    int           nstr;
    logic [31:0]  d0, d1;
  } vec_t;
  vec_t vt[7];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    int w = 0;
    while (in_ready !== 1'b1 && w < 50) begin @(posedge clock); #1; w++; end
    if (w == 50) begin nvec++; nerr++; $display("FAIL in_ready_wait: got %b want 1", in_ready); end
    in_valid = 1'b1; in_data = b;
    @(posedge clock); #1;
    in_valid = 1'b0;
    repeat (gap) begin @(posedge clock); #1; end
  endtask

  function automatic int gp(input int maxgap);
    return (maxgap == 0) ? 0 : int'($urandom_range(0, maxgap));
  endfunction

  task automatic send_frame(input logic [31:0] ws[$], input int maxgap, input logic [7:0] adj);
    logic [7:0] s = 8'h00;
    int n = ws.size();
    send(8'hA5, gp(maxgap));
    send(n[7:0], gp(maxgap));
    send(n[15:8], gp(maxgap));
    foreach (ws[i])
      for (int j = 0; j < 4; j++) begin
        s = s + ws[i][j*8 +: 8];
        send(ws[i][j*8 +: 8], gp(maxgap));
      end
    send(s + adj, 0);
  endtask

  task automatic settle();
    repeat (3) begin @(posedge clock); #1; end
  endtask

  task automatic chk_strobes(input string nm, input logic [31:0] ws[$]);
    int bad = 0;
    chk({nm, "_count"}, sq_d.size(), ws.size());
    if (sq_d.size() == ws.size())
      foreach (ws[i]) if (sq_d[i] !== ws[i] || sq_a[i] != i) bad++;
    chk({nm, "_words"}, bad, 0);
  endtask

  initial begin
    logic [31:0] fw[$], big[$];
    int cyc, r;
    bit seen;

    vt[0] = '{12, 128'hA5_02_00_13_05_50_00_93_05_A0_00_A0, 0, 1'b1, 1'b0, 2, 32'h00500513, 32'h00A00593};
    vt[1] = '{12, 128'hA5_02_00_13_05_50_00_93_05_A0_00_A1, 0, 1'b0, 1'b1, 2, 32'h00500513, 32'h00A00593};
    vt[2] = '{4,  128'hA5_00_00_00,                          0, 1'b1, 1'b0, 0, 32'h0, 32'h0};
    vt[3] = '{4,  128'hA5_00_00_01,                          0, 1'b0, 1'b1, 0, 32'h0, 32'h0};
    vt[4] = '{3,  128'hA5_01_04,                             0, 1'b0, 1'b1, 0, 32'h0, 32'h0};
    vt[5] = '{10, 128'h00_13_A5_01_00_78_56_34_12_14,        2, 1'b1, 1'b0, 1, 32'h12345678, 32'h0};
    vt[6] = '{8,  128'hA5_01_00_A5_A5_A5_A5_94,              0, 1'b1, 1'b0, 1, 32'hA5A5A5A5, 32'h0};
    fw = '{32'h00500513, 32'h00A00593, 32'hDEADBEEF, 32'h0000A5A5};

    #3;
    chk("reset_ctl", {in_ready, mem_write_enable, cpu_enable, busy, load_done, load_error, mem_address}, 0);
    chk("reset_data", mem_write_data, 0);
    @(negedge clock) reset = 1'b1;
    @(posedge clock); #1;
    chk("in_ready_after_reset", in_ready, 1);

    for (int i = 0; i < 7; i++) begin
      sq_a.delete(); sq_d.delete();
      for (int k = 0; k < vt[i].nb; k++) begin
        send(vt[i].bytes[(vt[i].nb - 1 - k) * 8 +: 8], 0);
        if (k == vt[i].mk) begin
          chk($sformatf("v%0d_cpu_off_in_frame", i), cpu_enable, 0);
          chk($sformatf("v%0d_busy_in_frame", i), busy, 1);
        end
      end
      settle();
      chk($sformatf("v%0d_done", i), load_done, vt[i].done);
      chk($sformatf("v%0d_error", i), load_error, vt[i].err);
      chk($sformatf("v%0d_cpu_enable", i), cpu_enable, vt[i].done);
      chk($sformatf("v%0d_busy", i), busy, 0);
      chk($sformatf("v%0d_strobes", i), sq_d.size(), vt[i].nstr);
      if (vt[i].nstr >= 1 && sq_d.size() >= 1) chk($sformatf("v%0d_word0", i), {sq_a[0], sq_d[0]}, {32'd0, vt[i].d0});
      if (vt[i].nstr >= 2 && sq_d.size() >= 2) chk($sformatf("v%0d_word1", i), {sq_a[1], sq_d[1]}, {32'd1, vt[i].d1});
    end

    // full capacity: exactly 2^ADDR_WIDTH words
    for (int i = 0; i < 1024; i++) big.push_back({i[7:0] ^ 8'h5A, 8'h00, i[15:8], i[7:0]});
    sq_a.delete(); sq_d.delete();
    send_frame(big, 0, 8'h00);
    settle();
    chk("full_done", load_done, 1);
    chk_strobes("full", big);

    // timeout in DATA, reloading from DONE
    sq_a.delete(); sq_d.delete();
    send(8'hA5, 0);
    chk("to_cpu_off_reload", cpu_enable, 0);
    send(8'h01, 0); send(8'h00, 0); send(8'h13, 0);
    chk("to_busy_before_stall", busy, 1);
    seen = 0; cyc = 0;
    while (!seen && cyc < 16) begin
      @(posedge clock); #1; cyc++;
      seen = (load_error === 1'b1);
    end
    chk("to_error_within_16", seen, 1);
    chk("to_not_early", (cyc >= 8), 1);
    chk("to_no_strobe", sq_d.size(), 0);
    send_frame(fw, 0, 8'h00);
    settle();
    chk("after_to_done", {load_done, load_error, cpu_enable}, 3'b101);
    chk_strobes("after_to", fw);

    // async reset mid-DATA at a random point and phase
    sq_a.delete(); sq_d.delete();
    send(8'hA5, 0); send(8'h04, gp(2)); send(8'h00, gp(2));
    r = int'($urandom_range(1, 10));
    for (int k = 0; k < r; k++) send(fw[k / 4][(k % 4) * 8 +: 8], gp(3));
    #2 reset = 1'b0;
    #1;
    chk("rst_mid_ctl", {in_ready, mem_write_enable, cpu_enable, busy, load_done, load_error, mem_address}, 0);
    chk("rst_mid_data", mem_write_data, 0);
    cyc = sq_d.size();
    @(posedge clock); #1 reset = 1'b1;
    settle();
    chk("rst_no_strobe", sq_d.size(), cyc);
    sq_a.delete(); sq_d.delete();
    send_frame(fw, 3, 8'h00);
    settle();
    chk("gapped_done", {load_done, load_error, cpu_enable}, 3'b101);
    chk_strobes("gapped", fw);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout want $finish");
    $fatal(1);
  end

endmodule
